lsu_store_buffer: RTL and testbench

Posted-write store buffer between the pipeline core's LSU port and the LSU side of the D-stage bus adapter. Each store is acknowledged to the core after one cycle and queued. Queued stores drain to the bus in program order whenever the bus is free. Loads bypass the queue unless they alias a queued word or target the strongly-ordered MMIO region, which removes store miss latency from the MEM stage.

---
 rtl/lsu_sb_pkg.sv | 29 ++
 rtl/sb_fifo.sv | 64 ++++++
 rtl/lsu_store_buffer.sv | 131 +++++++++++++
 tb/tb_lsu_store_buffer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_sb_pkg.sv
// Shared types and constants for the LSU posted-write store buffer.
package lsu_sb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  localparam logic [ADDR_W-1:0] MMIO_MASK_DEF = 32'hF000_0000;
  localparam logic [ADDR_W-1:0] MMIO_BASE_DEF = 32'h1000_0000;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_LOAD  = 2'd1,
    M_DRAIN = 2'd2
  } mstate_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } sb_entry_t;

  function automatic logic is_mmio(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] mask,
                                   input logic [ADDR_W-1:0] base);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue with occupancy count and per-entry word-address match.
import lsu_sb_pkg::*;

module sb_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  sb_entry_t                i_push_entry,
  input  logic                     i_pop,
  input  logic [ADDR_W-3:0]        i_probe_word,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output sb_entry_t                o_head,
  output logic [DEPTH-1:0]         o_match
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  sb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   w_off [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + AW'(1);
      if (i_pop)  r_head <= r_head + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: validity is tracked by head/count.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    o_match = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_off[i]   = AW'(i) - r_head;
      o_match[i] = ({1'b0, w_off[i]} < r_count) && (r_mem[i].addr[ADDR_W-1:2] == i_probe_word);
    end
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/lsu_store_buffer.sv
// Posted-write store buffer: acks stores in one cycle, drains them in order,
// and lets non-aliasing, non-MMIO loads bypass the queue.
import lsu_sb_pkg::*;

module lsu_store_buffer #(
  parameter int unsigned       DEPTH     = 4,
  parameter logic [ADDR_W-1:0] MMIO_MASK = MMIO_MASK_DEF,
  parameter logic [ADDR_W-1:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_wen,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic [MASK_W-1:0] i_cpu_wmask,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_mem_req,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_wmask,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_sb_empty
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  mstate_e           r_state;
  mstate_e           w_next;
  logic              r_busy;
  logic              r_st_ack;
  logic [ADDR_W-1:0] r_ld_addr;

  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  sb_entry_t         w_head;
  sb_entry_t         w_push_entry;
  logic [DEPTH-1:0]  w_match;
  logic              w_store_acc;
  logic              w_conflict;
  logic              w_ld_ok;
  logic              w_ld_go;
  logic              w_pop;
  logic              w_ld_done;

  assign w_push_entry = '{addr: i_cpu_addr, wdata: i_cpu_wdata, wmask: i_cpu_wmask};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (w_store_acc),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_probe_word (i_cpu_addr[ADDR_W-1:2]),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_head       (w_head),
    .o_match      (w_match)
  );

  // Full is sampled at cycle start, so a slot freed by a drain is usable next cycle.
  assign w_store_acc = i_cpu_req & i_cpu_wen & ~r_busy & ~w_full;
  assign w_conflict  = (|w_match) | (is_mmio(i_cpu_addr, MMIO_MASK, MMIO_BASE) & (w_count != '0));
  assign w_ld_ok     = i_cpu_req & ~i_cpu_wen & ~r_busy & ~w_conflict;
  assign w_pop       = (r_state == M_DRAIN) & i_mem_rvalid;
  assign w_ld_done   = (r_state == M_LOAD) & i_mem_rvalid;

  assign o_cpu_rvalid = r_st_ack | w_ld_done;
  assign o_cpu_rdata  = w_ld_done ? i_mem_rdata : '0;
  assign o_sb_empty   = w_empty & (r_state != M_DRAIN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= M_IDLE;
    else       r_state <= w_next;
  end

  // Bus sequencing; a pending load wins over draining when the bus is idle.
  always_comb begin
    w_next      = r_state;
    w_ld_go     = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wmask = '0;
    case (r_state)
      M_IDLE: begin
        if (w_ld_ok) begin
          w_next  = M_LOAD;
          w_ld_go = 1'b1;
        end else if (!w_empty) begin
          w_next = M_DRAIN;
        end
      end
      M_LOAD: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_ld_addr;
        if (i_mem_rvalid) w_next = M_IDLE;
      end
      M_DRAIN: begin
        o_mem_req   = 1'b1;
        o_mem_wen   = 1'b1;
        o_mem_addr  = w_head.addr;
        o_mem_wdata = w_head.wdata;
        o_mem_wmask = w_head.wmask;
        if (i_mem_rvalid) w_next = M_IDLE;
      end
      default: w_next = M_IDLE;
    endcase
  end

  // Core-side tracking: busy spans capture through the completion cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy    <= 1'b0;
      r_st_ack  <= 1'b0;
      r_ld_addr <= '0;
    end else begin
      r_st_ack <= w_store_acc;
      if (o_cpu_rvalid)               r_busy <= 1'b0;
      else if (w_store_acc | w_ld_go) r_busy <= 1'b1;
      if (w_ld_go) r_ld_addr <= i_cpu_addr;
    end
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer with a stallable bus responder that logs every completion.
module tb_lsu_store_buffer;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic        o_cpu_rvalid;
  logic [31:0] o_cpu_rdata;
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        o_sb_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          bus_stall = 1'b0;
  bit          bus_stray = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  bit          log_wen  [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_mask [$];
  int          log_cyc  [$];

  lsu_store_buffer #(.DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_req    (cpu_req),
    .i_cpu_wen    (cpu_wen),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_wmask  (cpu_wmask),
    .o_cpu_rvalid (o_cpu_rvalid),
    .o_cpu_rdata  (o_cpu_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_wen    (o_mem_wen),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_sb_empty   (o_sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: completes a request in the first unstalled cycle it is seen.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (bus_stray) begin
        mem_rvalid = 1'b1;
      end else if (o_mem_req && !bus_stall && !rst) begin
        mem_rvalid = 1'b1;
        if (!o_mem_wen) mem_rdata = bus_rdata;
        log_wen.push_back(o_mem_wen);
        log_addr.push_back(o_mem_addr);
        log_data.push_back(o_mem_wdata);
        log_mask.push_back(o_mem_wmask);
        log_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stall(input bit v);
    @(negedge clk);
    bus_stall = v;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int k = 0; k < budget && log_addr.size() < n; k++) tick();
  endtask

  task automatic core_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            input int budget, output int lat, output int rvc);
    tick();
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
    lat = -1; rvc = -1;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (o_cpu_rvalid) begin lat = k; rvc = cyc; break; end
      tick();
    end
    cpu_req = 1'b0; cpu_wen = 1'b0;
  endtask

  task automatic core_load(input logic [31:0] a, input int budget,
                           output int lat, output logic [31:0] rd, output int rvc);
    tick();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = a; cpu_wdata = 32'h0; cpu_wmask = 4'h0;
    lat = -1; rd = 32'h0; rvc = -1;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (o_cpu_rvalid) begin lat = k; rd = o_cpu_rdata; rvc = cyc; break; end
      tick();
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (o_cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", o_cpu_rvalid); end
    n_checks++; if (o_cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", o_cpu_rdata); end
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", o_mem_req); end
    n_checks++;
    if ({o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask} !== 69'h0) begin
      n_fail++; $display("FAIL rst_mem_fields: got wen=%b addr=%h data=%h mask=%h want all 0",
                         o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask);
    end
    n_checks++; if (o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL rst_sb_empty: got %b want 1", o_sb_empty); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea [3] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    logic [31:0] ed [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    logic [3:0]  em [3] = '{4'hF, 4'h3, 4'hC};
    int lat, rvc, base;
    set_stall(1'b1);
    base = log_addr.size();
    for (int i = 0; i < 3; i++) begin
      core_store(ea[i], ed[i], em[i], 10, lat, rvc);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_store_lat[%0d]: got %0d want 1", i, lat); end
    end
    n_checks++; if (dut.w_count !== 3'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", dut.w_count); end
    n_checks++;
    if (o_mem_req !== 1'b1 || o_mem_wen !== 1'b1 || o_mem_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL b2b_drain_head: got req=%b wen=%b addr=%h want 1 1 80000000", o_mem_req, o_mem_wen, o_mem_addr);
    end
    set_stall(1'b0);
    wait_log(base + 3, 40);
    n_checks++; if (log_addr.size() !== base + 3) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want %0d", log_addr.size() - base, 3); end
    for (int i = 0; i < 3; i++) begin
      if (log_addr.size() > base + i) begin
        n_checks++;
        if (log_wen[base+i] !== 1'b1 || log_addr[base+i] !== ea[i] || log_data[base+i] !== ed[i] || log_mask[base+i] !== em[i]) begin
          n_fail++; $display("FAIL b2b_write[%0d]: got wen=%b addr=%h data=%h mask=%h want 1 %h %h %h",
                             i, log_wen[base+i], log_addr[base+i], log_data[base+i], log_mask[base+i], ea[i], ed[i], em[i]);
        end
      end
    end
    repeat (3) tick();
    n_checks++; if (o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty_after: got %b want 1", o_sb_empty); end
  endtask

  task automatic test_full();
    int lat, rvc, lat5, rvc5, base;
    set_stall(1'b1);
    base = log_addr.size();
    for (int i = 0; i < 4; i++) begin
      core_store(32'h8000_0300 + 32'(4*i), 32'(i + 1), 4'hF, 10, lat, rvc);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL full_store_lat[%0d]: got %0d want 1", i, lat); end
    end
    n_checks++; if (dut.w_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", dut.w_count); end
    fork
      core_store(32'h8000_0310, 32'h5, 4'hF, 40, lat5, rvc5);
      begin
        repeat (6) @(negedge clk);
        bus_stall = 1'b0;
      end
    join
    n_checks++; if (lat5 < 3) begin n_fail++; $display("FAIL full_fifth_waits: got lat %0d want >= 3", lat5); end
    n_checks++;
    if (log_cyc.size() <= base || rvc5 !== log_cyc[base] + 2) begin
      n_fail++; $display("FAIL full_fifth_ack_cycle: got %0d want first-drain-cycle+2 (%0d)", rvc5,
                         (log_cyc.size() > base) ? log_cyc[base] + 2 : -1);
    end
    wait_log(base + 5, 40);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (log_addr.size() <= base + i || log_addr[base+i] !== 32'h8000_0300 + 32'(4*i) || log_data[base+i] !== 32'(i + 1)) begin
        n_fail++; $display("FAIL full_order[%0d]: got addr=%h data=%h want %h %h", i,
                           (log_addr.size() > base + i) ? log_addr[base+i] : 32'hx,
                           (log_data.size() > base + i) ? log_data[base+i] : 32'hx,
                           32'h8000_0300 + 32'(4*i), 32'(i + 1));
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_load_idle();
    int lat, rvc, base;
    logic [31:0] rd;
    base = log_addr.size();
    bus_rdata = 32'hCAFE_F00D;
    core_load(32'h8000_0200, 10, lat, rd, rvc);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL idle_load_lat: got %0d want 1", lat); end
    n_checks++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL idle_load_rdata: got %h want cafef00d", rd); end
    n_checks++;
    if (log_addr.size() <= base || log_wen[base] !== 1'b0 || log_addr[base] !== 32'h8000_0200) begin
      n_fail++; $display("FAIL idle_load_bus: got n=%0d want read at 80000200", log_addr.size() - base);
    end
    repeat (3) tick();
  endtask

  task automatic test_bypass();
    int lat, rvc, base;
    logic [31:0] rd;
    set_stall(1'b1);
    base = log_addr.size();
    bus_rdata = 32'hDEAD_BEEF;
    core_store(32'h8000_0400, 32'hAAAA_0001, 4'hF, 10, lat, rvc);
    core_store(32'h8000_0010, 32'hBBBB_0002, 4'hF, 10, lat, rvc);
    fork
      core_load(32'h8000_0100, 40, lat, rd, rvc);
      begin
        repeat (4) @(negedge clk);
        bus_stall = 1'b0;
      end
    join
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rdata: got %h want deadbeef", rd); end
    wait_log(base + 3, 40);
    n_checks++;
    if (log_addr.size() < base + 3 || log_wen[base+1] !== 1'b0 || log_addr[base+1] !== 32'h8000_0100) begin
      n_fail++; $display("FAIL bypass_order_load: got n=%0d want read 80000100 as second bus op", log_addr.size() - base);
    end
    n_checks++;
    if (log_addr.size() < base + 3 || log_wen[base+2] !== 1'b1 || log_addr[base+2] !== 32'h8000_0010) begin
      n_fail++; $display("FAIL bypass_order_store: got n=%0d want write 80000010 after the load", log_addr.size() - base);
    end
    n_checks++;
    if (log_cyc.size() < base + 2 || rvc !== log_cyc[base+1]) begin
      n_fail++; $display("FAIL bypass_rvalid_cycle: got %0d want mem_rvalid cycle", rvc);
    end
    repeat (3) tick();
  endtask

  task automatic test_alias();
    int lat, rvc, base;
    logic [31:0] rd;
    set_stall(1'b1);
    base = log_addr.size();
    bus_rdata = 32'h1234_5678;
    core_store(32'h8000_0500, 32'h0, 4'hF, 10, lat, rvc);
    core_store(32'h8000_0010, 32'h1234_5678, 4'hF, 10, lat, rvc);
    fork
      core_load(32'h8000_0012, 40, lat, rd, rvc);
      begin
        repeat (4) @(negedge clk);
        bus_stall = 1'b0;
      end
    join
    wait_log(base + 3, 40);
    n_checks++;
    if (log_addr.size() < base + 3 || log_wen[base+1] !== 1'b1 || log_addr[base+1] !== 32'h8000_0010 || log_data[base+1] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL alias_store_first: got n=%0d want write 80000010 before load", log_addr.size() - base);
    end
    n_checks++;
    if (log_addr.size() < base + 3 || log_wen[base+2] !== 1'b0 || log_addr[base+2] !== 32'h8000_0012) begin
      n_fail++; $display("FAIL alias_load_addr: got n=%0d want read 80000012 third", log_addr.size() - base);
    end
    n_checks++;
    if (log_cyc.size() < base + 3 || log_cyc[base+2] !== log_cyc[base+1] + 2) begin
      n_fail++; $display("FAIL alias_load_cycle: got %0d want store rvalid cycle+2", (log_cyc.size() >= base + 3) ? log_cyc[base+2] - log_cyc[base+1] : -1);
    end
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL alias_rdata: got %h want 12345678", rd); end
    repeat (3) tick();
  endtask

  task automatic test_mmio();
    int lat, rvc, base;
    logic [31:0] rd;
    set_stall(1'b1);
    base = log_addr.size();
    bus_rdata = 32'h0000_00A5;
    core_store(32'h8000_0700, 32'h55, 4'hF, 10, lat, rvc);
    core_store(32'h8000_0720, 32'h66, 4'hF, 10, lat, rvc);
    fork
      core_load(32'h1000_0005, 40, lat, rd, rvc);
      begin
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_sb_empty !== 1'b0 || o_mem_wen !== 1'b1 || o_mem_addr !== 32'h8000_0700) begin
          n_fail++; $display("FAIL mmio_wait_state: got empty=%b wen=%b addr=%h want 0 1 80000700", o_sb_empty, o_mem_wen, o_mem_addr);
        end
        bus_stall = 1'b0;
      end
    join
    wait_log(base + 3, 40);
    n_checks++;
    if (log_addr.size() < base + 3 || log_wen[base+2] !== 1'b0 || log_addr[base+2] !== 32'h1000_0005) begin
      n_fail++; $display("FAIL mmio_order: got n=%0d want MMIO read after both writes", log_addr.size() - base);
    end
    n_checks++;
    if (log_cyc.size() < base + 3 || log_cyc[base+2] !== log_cyc[base+1] + 2) begin
      n_fail++; $display("FAIL mmio_issue_cycle: got %0d want last-write cycle+2", (log_cyc.size() >= base + 3) ? log_cyc[base+2] - log_cyc[base+1] : -1);
    end
    n_checks++; if (rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL mmio_rdata: got %h want 000000a5", rd); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_drain();
    int lat, rvc, base;
    set_stall(1'b1);
    core_store(32'h8000_0600, 32'h61, 4'hF, 10, lat, rvc);
    core_store(32'h8000_0604, 32'h62, 4'hF, 10, lat, rvc);
    n_checks++;
    if (dut.w_count !== 3'd2 || o_mem_req !== 1'b1 || o_mem_wen !== 1'b1) begin
      n_fail++; $display("FAIL rmd_setup: got count=%0d req=%b wen=%b want 2 1 1", dut.w_count, o_mem_req, o_mem_wen);
    end
    rst = 1'b1;
    #1;
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rmd_mem_req: got %b want 0", o_mem_req); end
    n_checks++; if (o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL rmd_sb_empty: got %b want 1", o_sb_empty); end
    n_checks++;
    if (o_cpu_rvalid !== 1'b0 || o_mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rmd_outputs: got rvalid=%b addr=%h want 0 0", o_cpu_rvalid, o_mem_addr);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_stray = 1'b1;
    tick();
    #1;
    n_checks++;
    if (o_mem_req !== 1'b0 || o_cpu_rvalid !== 1'b0 || o_sb_empty !== 1'b1) begin
      n_fail++; $display("FAIL rmd_stray: got req=%b rvalid=%b empty=%b want 0 0 1", o_mem_req, o_cpu_rvalid, o_sb_empty);
    end
    @(negedge clk);
    bus_stray = 1'b0;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b0 || o_cpu_rvalid !== 1'b0 || o_sb_empty !== 1'b1) begin
      n_fail++; $display("FAIL rmd_after_stray: got req=%b rvalid=%b empty=%b want 0 0 1", o_mem_req, o_cpu_rvalid, o_sb_empty);
    end
    set_stall(1'b0);
    base = log_addr.size();
    core_store(32'h8000_0640, 32'h77, 4'h1, 10, lat, rvc);
    wait_log(base + 1, 20);
    repeat (6) tick();
    n_checks++;
    if (log_addr.size() !== base + 1 || log_addr[base] !== 32'h8000_0640 || log_data[base] !== 32'h77) begin
      n_fail++; $display("FAIL rmd_post_reset_drain: got n=%0d first=%h want 1 write to 80000640",
                         log_addr.size() - base, (log_addr.size() > base) ? log_addr[base] : 32'hx);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_wmask = 4'h0;
    test_reset();
    test_back_to_back();
    test_full();
    test_load_idle();
    test_bypass();
    test_alias();
    test_mmio();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
